fetch_stage: RTL and testbench

- Instruction-fetch (IF) stage: the producer side of the IF/ID pipeline register.
- Holds the PC and issues req/ack reads to instruction memory.
- Delivers each instruction word with its PC+4 to IF/ID, together with a valid flag.
- Obeys stall and flush from the hazard unit and branch/jump redirects from decode; discards in-flight fetches that a redirect has made stale.

---
 rtl/mips_pkg.sv | 18 +
 rtl/pc_next_sel.sv | 30 +++
 rtl/fetch_stage.sv | 144 ++++++++++++++
 tb/tb_fetch_stage.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and defaults for the fetch stage
// Purpose: fetch FSM state encoding, instruction width, reset PC / NOP defaults.
// Ports: none (package).
package mips_pkg;

  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - redirect/target select with alignment masking and PC+4
// Purpose: combinational next-PC helpers for the fetch stage.
// Ports:
//   i_pcsrc, i_branch_target : taken branch and its target
//   i_jump, i_jump_target    : jump and its target (wins over branch)
//   i_pc                     : current PC
//   o_redirect               : jump | branch
//   o_target                 : selected target, word aligned
//   o_pc_plus4               : i_pc + 4, modulo 2^32
module pc_next_sel
  import mips_pkg::*;
(
  input  logic               i_pcsrc,
  input  logic [INSTR_W-1:0] i_branch_target,
  input  logic               i_jump,
  input  logic [INSTR_W-1:0] i_jump_target,
  input  logic [INSTR_W-1:0] i_pc,
  output logic               o_redirect,
  output logic [INSTR_W-1:0] o_target,
  output logic [INSTR_W-1:0] o_pc_plus4
);

  logic [INSTR_W-1:0] w_raw_target;

  assign o_redirect   = i_jump | i_pcsrc;
  assign w_raw_target = i_jump ? i_jump_target : i_branch_target;
  assign o_target     = {w_raw_target[INSTR_W-1:2], 2'b00};
  assign o_pc_plus4   = i_pc + 32'd4;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage feeding the IF/ID register
// Purpose: holds the PC, issues req/ack reads to instruction memory, hands
//   each word plus its PC+4 to IF/ID, honours stall/flush and redirects, and
//   discards fetches made stale by a redirect.
// Ports:
//   CLK, RST                   : clock, synchronous active-high reset
//   StallF                     : IF/ID not accepting this cycle
//   PCSrcD/PCBranchD           : branch taken / target
//   JumpD/PCJumpD              : jump / target
//   imem_req/imem_addr         : memory request and address (= PC)
//   imem_ack/imem_rdata        : memory completion and data
//   instrF/PCPlus4F/validF     : instruction, its PC+4, and qualifier
//   FlushD                     : clear IF/ID on redirect
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               StallF,
  input  logic               PCSrcD,
  input  logic [INSTR_W-1:0] PCBranchD,
  input  logic               JumpD,
  input  logic [INSTR_W-1:0] PCJumpD,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instrF,
  output logic [INSTR_W-1:0] PCPlus4F,
  output logic               validF,
  output logic               FlushD
);

  fetch_state_e       r_state;
  logic [INSTR_W-1:0] r_pc;
  logic [INSTR_W-1:0] r_pending;
  logic [INSTR_W-1:0] r_hold;

  fetch_state_e       w_state_nxt;
  logic [INSTR_W-1:0] w_pc_nxt;
  logic [INSTR_W-1:0] w_pending_nxt;
  logic [INSTR_W-1:0] w_hold_nxt;
  logic               w_req;
  logic               w_valid;
  logic               w_use_hold;

  logic               w_redirect;
  logic [INSTR_W-1:0] w_target;
  logic [INSTR_W-1:0] w_pc_plus4;

  pc_next_sel u_pc_next_sel (
    .i_pcsrc         (PCSrcD),
    .i_branch_target (PCBranchD),
    .i_jump          (JumpD),
    .i_jump_target   (PCJumpD),
    .i_pc            (r_pc),
    .o_redirect      (w_redirect),
    .o_target        (w_target),
    .o_pc_plus4      (w_pc_plus4)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= BOOT;
      r_pc      <= RESET_PC;
      r_pending <= '0;
      r_hold    <= NOP_INSTR;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_pending <= w_pending_nxt;
      r_hold    <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_pending_nxt = r_pending;
    w_hold_nxt    = r_hold;
    w_req         = 1'b0;
    w_valid       = 1'b0;
    w_use_hold    = 1'b0;
    case (r_state)
      BOOT: begin
        if (w_redirect) w_pc_nxt = w_target;
        w_state_nxt = FETCH;
      end
      FETCH: begin
        w_req = 1'b1;
        if (imem_ack) begin
          if (w_redirect) begin
            w_pc_nxt = w_target;
          end else if (!StallF) begin
            w_valid  = 1'b1;
            w_pc_nxt = w_pc_plus4;
          end else begin
            // IF/ID is full: park the word and drop the request until it drains.
            w_hold_nxt  = imem_rdata;
            w_state_nxt = HOLD;
          end
        end else if (w_redirect) begin
          // Request must stay up at the old PC until the memory completes it.
          w_pending_nxt = w_target;
          w_state_nxt   = DROP;
        end
      end
      HOLD: begin
        w_use_hold = 1'b1;
        if (w_redirect) begin
          w_pc_nxt    = w_target;
          w_state_nxt = FETCH;
        end else if (!StallF) begin
          w_valid     = 1'b1;
          w_pc_nxt    = w_pc_plus4;
          w_state_nxt = FETCH;
        end
      end
      DROP: begin
        w_req = 1'b1;
        if (imem_ack) begin
          w_pc_nxt    = w_redirect ? w_target : r_pending;
          w_state_nxt = FETCH;
        end else if (w_redirect) begin
          w_pending_nxt = w_target;
        end
      end
      default: w_state_nxt = BOOT;
    endcase
  end

  // Reset masks the handshake outputs combinationally so an outstanding
  // request is abandoned in the reset cycle itself.
  assign imem_req  = w_req & ~RST;
  assign validF    = w_valid & ~RST;
  assign FlushD    = w_redirect & ~RST & (r_state != BOOT);
  assign imem_addr = r_pc;
  assign instrF    = validF ? (w_use_hold ? r_hold : imem_rdata) : NOP_INSTR;
  assign PCPlus4F  = RST ? (RESET_PC + 32'd4) : w_pc_plus4;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed table-driven bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] K = 32'hA5A5A5A5;

  logic        CLK = 1'b0;
  logic        RST, StallF, PCSrcD, JumpD, imem_ack;
  logic [31:0] PCBranchD, PCJumpD;
  logic        imem_req, validF, FlushD;
  logic [31:0] imem_addr, imem_rdata, instrF, PCPlus4F;

  logic        RST2, imem_ack2;
  logic        imem_req2, validF2, FlushD2;
  logic [31:0] imem_addr2, imem_rdata2, instrF2, PCPlus4F2;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  assign imem_rdata  = imem_addr ^ K;
  assign imem_rdata2 = imem_addr2 ^ K;

  fetch_stage u_dut (
    .CLK(CLK), .RST(RST), .StallF(StallF), .PCSrcD(PCSrcD), .PCBranchD(PCBranchD),
    .JumpD(JumpD), .PCJumpD(PCJumpD), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instrF(instrF),
    .PCPlus4F(PCPlus4F), .validF(validF), .FlushD(FlushD)
  );

  fetch_stage #(.RESET_PC(32'hFFFFFFFC), .NOP_INSTR(32'h0)) u_dut_wrap (
    .CLK(CLK), .RST(RST2), .StallF(StallF), .PCSrcD(PCSrcD), .PCBranchD(PCBranchD),
    .JumpD(JumpD), .PCJumpD(PCJumpD), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .instrF(instrF2),
    .PCPlus4F(PCPlus4F2), .validF(validF2), .FlushD(FlushD2)
  );

  typedef struct {
    logic        rst, stall, br;
    logic [31:0] brt;
    logic        j;
    logic [31:0] jt;
    logic        ack;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] einstr;
    logic [31:0] epc4;
    logic        eflush;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic stall, input logic br, input logic [31:0] brt,
                     input logic j, input logic [31:0] jt, input logic ack,
                     input logic ereq, input logic [31:0] eaddr, input logic evalid,
                     input logic [31:0] einstr, input logic [31:0] epc4, input logic eflush);
    vec_t v;
    v.rst = rst; v.stall = stall; v.br = br; v.brt = brt; v.j = j; v.jt = jt; v.ack = ack;
    v.ereq = ereq; v.eaddr = eaddr; v.evalid = evalid; v.einstr = einstr;
    v.epc4 = epc4; v.eflush = eflush;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%h expected=%h", name, idx, act, exp);
    end
  endtask

  initial begin
    RST = 1'b1; StallF = 1'b0; PCSrcD = 1'b0; JumpD = 1'b0; imem_ack = 1'b0;
    PCBranchD = '0; PCJumpD = '0; RST2 = 1'b1; imem_ack2 = 1'b0;

    //   rst st br brt        j  jt        ack  req addr      v  instr        pc4       fl
    add(1, 0, 1, 32'h80,    0, 0,         1,   0, 32'h0,    0, 32'h0,       32'h4,    0); // reset, redirect ignored
    add(0, 0, 0, 0,         0, 0,         1,   0, 32'h0,    0, 32'h0,       32'h4,    0); // BOOT
    add(0, 0, 0, 0,         0, 0,         1,   1, 32'h0,    1, 32'h0^K,     32'h4,    0);
    add(0, 0, 0, 0,         0, 0,         1,   1, 32'h4,    1, 32'h4^K,     32'h8,    0);
    add(0, 0, 0, 0,         0, 0,         1,   1, 32'h8,    1, 32'h8^K,     32'hC,    0);
    add(0, 0, 0, 0,         0, 0,         1,   1, 32'hC,    1, 32'hC^K,     32'h10,   0);
    add(0, 1, 0, 0,         0, 0,         1,   1, 32'h10,   0, 32'h0,       32'h14,   0); // stall on ack
    add(0, 1, 0, 0,         0, 0,         0,   0, 32'h10,   0, 32'h0,       32'h14,   0); // HOLD
    add(0, 1, 0, 0,         0, 0,         0,   0, 32'h10,   0, 32'h0,       32'h14,   0);
    add(0, 1, 0, 0,         0, 0,         0,   0, 32'h10,   0, 32'h0,       32'h14,   0);
    add(0, 0, 0, 0,         0, 0,         0,   0, 32'h10,   1, 32'h10^K,    32'h14,   0); // release
    add(0, 0, 0, 0,         0, 0,         0,   1, 32'h14,   0, 32'h0,       32'h18,   0); // latency 3
    add(0, 0, 0, 0,         0, 0,         0,   1, 32'h14,   0, 32'h0,       32'h18,   0);
    add(0, 0, 0, 0,         0, 0,         1,   1, 32'h14,   1, 32'h14^K,    32'h18,   0);
    add(0, 0, 0, 0,         0, 0,         0,   1, 32'h18,   0, 32'h0,       32'h1C,   0);
    add(0, 0, 1, 32'h103,   0, 0,         1,   1, 32'h18,   0, 32'h0,       32'h1C,   1); // branch, misaligned
    add(0, 0, 0, 0,         0, 0,         0,   1, 32'h100,  0, 32'h0,       32'h104,  0);
    add(0, 0, 1, 32'h500,   1, 32'h40,    1,   1, 32'h100,  0, 32'h0,       32'h104,  1); // jump wins
    add(0, 0, 1, 32'h200,   0, 0,         0,   1, 32'h40,   0, 32'h0,       32'h44,   1); // -> DROP
    add(0, 0, 0, 0,         1, 32'h301,   0,   1, 32'h40,   0, 32'h0,       32'h44,   1); // latest wins
    add(0, 0, 0, 0,         0, 0,         0,   1, 32'h40,   0, 32'h0,       32'h44,   0);
    add(0, 0, 0, 0,         0, 0,         1,   1, 32'h40,   0, 32'h0,       32'h44,   0); // stale ack
    add(0, 0, 0, 0,         0, 0,         1,   1, 32'h300,  1, 32'h300^K,   32'h304,  0);
    add(0, 0, 1, 32'h600,   0, 0,         0,   1, 32'h304,  0, 32'h0,       32'h308,  1); // -> DROP
    add(1, 0, 0, 0,         0, 0,         0,   0, 32'h304,  0, 32'h0,       32'h4,    0); // reset in DROP
    add(0, 0, 0, 0,         0, 0,         1,   0, 32'h0,    0, 32'h0,       32'h4,    0); // BOOT
    add(0, 0, 0, 0,         0, 0,         1,   1, 32'h0,    1, 32'h0^K,     32'h4,    0);
    add(0, 0, 1, 32'h700,   0, 0,         0,   1, 32'h4,    0, 32'h0,       32'h8,    1); // -> DROP
    add(0, 0, 0, 0,         1, 32'h800,   1,   1, 32'h4,    0, 32'h0,       32'h8,    1); // redirect on ack
    add(0, 0, 0, 0,         0, 0,         1,   1, 32'h800,  1, 32'h800^K,   32'h804,  0);
    add(1, 0, 0, 0,         0, 0,         0,   0, 32'h804,  0, 32'h0,       32'h4,    0);
    add(0, 0, 1, 32'h900,   0, 0,         0,   0, 32'h0,    0, 32'h0,       32'h4,    0); // redirect in BOOT
    add(0, 0, 0, 0,         0, 0,         1,   1, 32'h900,  1, 32'h900^K,   32'h904,  0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      RST = vecs[i].rst; StallF = vecs[i].stall; PCSrcD = vecs[i].br; PCBranchD = vecs[i].brt;
      JumpD = vecs[i].j; PCJumpD = vecs[i].jt; imem_ack = vecs[i].ack;
      #1;
      chk("imem_req",  i, {31'b0, imem_req}, {31'b0, vecs[i].ereq});
      chk("imem_addr", i, imem_addr,         vecs[i].eaddr);
      chk("validF",    i, {31'b0, validF},   {31'b0, vecs[i].evalid});
      chk("instrF",    i, instrF,            vecs[i].einstr);
      chk("PCPlus4F",  i, PCPlus4F,          vecs[i].epc4);
      chk("FlushD",    i, {31'b0, FlushD},   {31'b0, vecs[i].eflush});
    end

    // Wrap-around instance: RESET_PC = 0xFFFFFFFC.
    @(negedge CLK);
    RST = 1'b0; StallF = 1'b0; PCSrcD = 1'b0; JumpD = 1'b0; imem_ack = 1'b0;
    RST2 = 1'b1; imem_ack2 = 1'b0;
    @(negedge CLK);
    RST2 = 1'b0;
    #1;
    chk("wrap_boot_req",  100, {31'b0, imem_req2}, 32'h0);
    chk("wrap_boot_pc4",  100, PCPlus4F2, 32'h0);
    @(negedge CLK);
    imem_ack2 = 1'b1;
    #1;
    chk("wrap_addr",   101, imem_addr2, 32'hFFFFFFFC);
    chk("wrap_valid",  101, {31'b0, validF2}, 32'h1);
    chk("wrap_instr",  101, instrF2, 32'h5A5A5A59);
    chk("wrap_pc4",    101, PCPlus4F2, 32'h0);
    @(negedge CLK);
    imem_ack2 = 1'b0;
    #1;
    chk("wrap_next_addr", 102, imem_addr2, 32'h0);
    chk("wrap_next_req",  102, {31'b0, imem_req2}, 32'h1);
    chk("wrap_next_valid", 102, {31'b0, validF2}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
